exec_sequencer: RTL and testbench

Control sequencer that drives the instruction decoder's execution strobes. It primes the instruction RAM, latches each fetched instruction word into an instruction register, and generates the EXEC1/EXEC2 phase strobes. It honours the decoder's E2 request for a second execute cycle, and stops the machine on STP. It sits between the instruction RAM output and the decoder: it consumes `E2` and produces `EXEC1`, `EXEC2` and the latched instruction.

---
 rtl/exec_sequencer_pkg.sv | 35 +++
 rtl/exec_sequencer_retire_counter.sv | 23 ++
 rtl/exec_sequencer.sv | 125 ++++++++++++
 tb/tb_exec_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execution sequencer: word width, opcode field, state codes.
// STP detection lives here so the top level and any future decoder agree on it.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_HI  = 14;
  localparam int OPC_LO  = 9;

  localparam logic [5:0] OP_STP = 6'b111111;
  localparam logic [5:0] OP_NOP = 6'b111110;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRIME = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_EXEC1 = 3'd4;
  localparam logic [2:0] ST_EXEC2 = 3'd5;
  localparam logic [2:0] ST_HALT  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_PRIME = ST_PRIME,
    S_LOAD  = ST_LOAD,
    S_PAUSE = ST_PAUSE,
    S_EXEC1 = ST_EXEC1,
    S_EXEC2 = ST_EXEC2,
    S_HALT  = ST_HALT
  } seq_state_t;

  // Bit 15 set marks the extended opcode space, where 111111 is not STP.
  function automatic logic is_stp(input logic [INSTR_W-1:0] w);
    return (w[15] == 1'b0) && (w[OPC_HI:OPC_LO] == OP_STP);
  endfunction

endpackage

// File: rtl/exec_sequencer_retire_counter.sv
// Retired-instruction counter: CNT_W-bit, wraps modulo 2^CNT_W, async active-high reset.
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/exec_sequencer.sv
// Execution sequencer: primes RAMi, latches IR, drives EXEC1/EXEC2 strobes, stops on STP.
// Optional macro EXEC_SEQ_STEP_EN adds the STEP input for single-stepping out of PAUSE.
//
// state | meaning
// IDLE  | waiting for RUN after reset
// PRIME | one-cycle FETCH_EN for the initial RAMi read
// LOAD  | IR <= instr; continue if RUN, else PAUSE
// PAUSE | IR held, waiting for RUN (or a STEP edge)
// EXEC1 | first execute strobe; STP -> HALT, E2 -> EXEC2, else LOAD
// EXEC2 | second execute strobe, then LOAD
// HALT  | stopped until RESET
module exec_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
`ifdef EXEC_SEQ_STEP_EN
  input  logic               STEP,
`endif
  input  logic               CLK,
  input  logic               RESET,
  input  logic               RUN,
  input  logic [INSTR_W-1:0] instr,
  input  logic               E2,
  output logic               FETCH_EN,
  output logic [INSTR_W-1:0] IR,
  output logic               EXEC1,
  output logic               EXEC2,
  output logic               HALTED,
  output logic [CNT_W-1:0]   RETIRED
);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [INSTR_W-1:0] r_ir;
  logic               r_exec1;
  logic               r_exec2;
  logic               r_fetch_en;
  logic               r_halted;
  logic               w_stp;
  logic               w_resume;
  logic               w_retire;

`ifdef EXEC_SEQ_STEP_EN
  logic r_step_q;
  logic w_step_rise;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= STEP;
    end
  end

  assign w_step_rise = STEP & ~r_step_q;
  assign w_resume    = RUN | w_step_rise;
`else
  assign w_resume    = RUN;
`endif

  assign w_stp = is_stp(r_ir);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (RUN) w_state_nxt = S_PRIME;
      S_PRIME: w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = RUN ? S_EXEC1 : S_PAUSE;
      S_PAUSE: if (w_resume) w_state_nxt = S_EXEC1;
      S_EXEC1: begin
        if (w_stp) begin
          w_state_nxt = S_HALT;
        end else if (E2) begin
          w_state_nxt = S_EXEC2;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_EXEC2: w_state_nxt = S_LOAD;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // An instruction retires when it leaves EXEC1 for anything but EXEC2, or leaves EXEC2.
  assign w_retire = ((r_state == S_EXEC1) && (w_state_nxt != S_EXEC2)) ||
                    (r_state == S_EXEC2);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_ir       <= '0;
      r_exec1    <= 1'b0;
      r_exec2    <= 1'b0;
      r_fetch_en <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      if (r_state == S_LOAD) begin
        r_ir <= instr;
      end
      r_exec1    <= (w_state_nxt == S_EXEC1);
      r_exec2    <= (w_state_nxt == S_EXEC2);
      r_fetch_en <= (w_state_nxt == S_PRIME);
      r_halted   <= (w_state_nxt == S_HALT);
    end
  end

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_inc   (w_retire),
    .o_count (RETIRED)
  );

  assign IR       = r_ir;
  assign EXEC1    = r_exec1;
  assign EXEC2    = r_exec2;
  assign FETCH_EN = r_fetch_en;
  assign HALTED   = r_halted;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: random programs and RUN patterns against a strobe-level model.
module tb_exec_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        RUN;
  logic [15:0] instr;
  logic        E2;
  logic        STEP;
  logic        FETCH_EN;
  logic [15:0] IR;
  logic        EXEC1;
  logic        EXEC2;
  logic        HALTED;
  logic [15:0] RETIRED;

  exec_sequencer #(.CNT_W(16)) dut (
`ifdef EXEC_SEQ_STEP_EN
    .STEP     (STEP),
`endif
    .CLK      (CLK),
    .RESET    (RESET),
    .RUN      (RUN),
    .instr    (instr),
    .E2       (E2),
    .FETCH_EN (FETCH_EN),
    .IR       (IR),
    .EXEC1    (EXEC1),
    .EXEC2    (EXEC2),
    .HALTED   (HALTED),
    .RETIRED  (RETIRED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_e2;
    logic [15:0] ir;
    int          ret;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] prog[64];
  bit          e2_tab[64];
  int          exec_idx;
  int          e1_cnt;
  int          e2_cnt;
  int          fetch_cnt;
  int          pass_cnt;
  int          total_cnt;

  task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic bit is_stp_word(input logic [15:0] w);
    return (w[15] == 1'b0) && (w[14:9] == 6'b111111);
  endfunction

  // RAM + decoder stand-in: after each EXEC1 the next program word is presented.
  always @(negedge CLK) begin
    if (EXEC1) begin
      E2 = e2_tab[exec_idx];
      if (exec_idx < 63) exec_idx++;
      instr = prog[exec_idx];
    end else begin
      E2 = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge CLK) begin
    if (!RESET) begin
      if (FETCH_EN) fetch_cnt++;
      if (EXEC1 || EXEC2) begin
        exp_t e;
        if (EXEC1) e1_cnt++;
        if (EXEC2) e2_cnt++;
        check("strobe_overlap", 64'(EXEC1 & EXEC2), 0);
        if (sb_q.size() == 0) begin
          check("sb_pending", 64'(sb_q.size()), 1);
        end else begin
          e = sb_q.pop_front();
          check("strobe_kind", 64'(EXEC2), 64'(e.is_e2));
          check("strobe_ir", 64'(IR), 64'(e.ir));
          check("strobe_retired", 64'(RETIRED), 64'(e.ret));
        end
      end
    end
  end

  task automatic gen_prog(input int n);
    logic [15:0] w;
    for (int k = 0; k < 64; k++) begin
      prog[k]   = 16'($urandom);
      e2_tab[k] = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < n - 1; k++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 4))
        0: w[14:9] = 6'b111110;
        1: begin w[15] = 1'b1; w[14:9] = 6'b111111; end
        default: ;
      endcase
      if (is_stp_word(w)) w[9] = 1'b0;
      prog[k] = w;
    end
    w = 16'($urandom);
    w[15] = 1'b0;
    w[14:9] = 6'b111111;
    prog[n-1] = w;
  endtask

  task automatic push_expected(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.is_e2 = 1'b0; e.ir = prog[k]; e.ret = k;
      sb_q.push_back(e);
      if (e2_tab[k] && !is_stp_word(prog[k])) begin
        e.is_e2 = 1'b1;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    RUN = 1'b0;
    STEP = 1'b0;
    sb_q.delete();
    exec_idx = 0;
    instr = prog[0];
    #1;
    check("rst_exec1", 64'(EXEC1), 0);
    check("rst_exec2", 64'(EXEC2), 0);
    check("rst_fetch_en", 64'(FETCH_EN), 0);
    check("rst_halted", 64'(HALTED), 0);
    check("rst_ir", 64'(IR), 0);
    check("rst_retired", 64'(RETIRED), 0);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    fetch_cnt = 0;
  endtask

  task automatic wait_halt(input int bound, input bit rand_run);
    int c = 0;
    while (!HALTED && c < bound) begin
      @(negedge CLK);
      if (rand_run) RUN = ($urandom_range(0, 3) != 0);
      c++;
    end
    check("halt_reached", 64'(HALTED), 1);
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      RUN = 1'($urandom_range(0, 1));
      check("halt_held", 64'(HALTED), 1);
    end
    check("halt_retired", 64'(RETIRED), 64'(n));
    check("halt_sb_empty", 64'(sb_q.size()), 0);
    check("single_fetch", 64'(fetch_cnt), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int cyc;
    int exp_halt;
    int b1;
    int b2;
    RESET = 1'b1; RUN = 1'b0; STEP = 1'b0; E2 = 1'b0; instr = '0;
    exec_idx = 0; e1_cnt = 0; e2_cnt = 0; fetch_cnt = 0;
    pass_cnt = 0; total_cnt = 0;

    // start-up timing with the documented first word
    gen_prog(2);
    prog[0] = 16'h0040; e2_tab[0] = 1'b0;
    do_reset();
    push_expected(2);
    @(negedge CLK);
    RUN = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      if (c == 1) check("start_fetch_c1", 64'(FETCH_EN), 1);
      if (c == 2) check("start_fetch_c2", 64'(FETCH_EN), 0);
      if (c == 3) check("start_exec1_c3", 64'(EXEC1), 1);
      if (c == 4) check("start_retired_c4", 64'(RETIRED), 1);
    end
    wait_halt(40, 1'b0);
    halt_hold(2);

    // RUN held high: halt cycle predicted from per-instruction lengths
    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(3, 12);
      gen_prog(n);
      do_reset();
      push_expected(n);
      exp_halt = 4;
      for (int k = 0; k < n - 1; k++) exp_halt += e2_tab[k] ? 3 : 2;
      @(negedge CLK);
      RUN = 1'b1;
      cyc = 0;
      while (!HALTED && cyc < 200) begin
        @(negedge CLK);
        cyc++;
      end
      check("halt_cycle", 64'(cyc), 64'(exp_halt));
      halt_hold(n);
    end

    // random RUN pattern: strobe sequence must not depend on stalls
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(3, 12);
      gen_prog(n);
      do_reset();
      push_expected(n);
      wait_halt(50 * n + 50, 1'b1);
      halt_hold(n);
    end

    // RUN dropped during EXEC2, then resume without refetch
    gen_prog(3);
    prog[0] = 16'h3800; e2_tab[0] = 1'b1;
    prog[1] = 16'h0040; e2_tab[1] = 1'b0;
    prog[2] = 16'h7E00; e2_tab[2] = 1'b0;
    do_reset();
    push_expected(3);
    RUN = 1'b1;
    cyc = 0;
    while (!EXEC2 && cyc < 20) begin @(negedge CLK); cyc++; end
    check("pause_saw_exec2", 64'(EXEC2), 1);
    RUN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    instr = 16'hBEEF;
    repeat (3) @(negedge CLK);
    check("pause_ir_held", 64'(IR), 16'h0040);
    check("pause_no_exec1", 64'(EXEC1), 0);
    check("pause_retired", 64'(RETIRED), 1);
    RUN = 1'b1;
    @(negedge CLK);
    check("resume_exec1", 64'(EXEC1), 1);
    wait_halt(20, 1'b0);
    halt_hold(3);

    // async reset in the middle of EXEC1
    n = 8;
    gen_prog(n);
    do_reset();
    push_expected(n);
    RUN = 1'b1;
    cyc = 0;
    while (!(EXEC1 && e1_cnt > 0 && exec_idx >= 2) && cyc < 40) begin @(negedge CLK); cyc++; end
    check("midrst_in_exec1", 64'(EXEC1), 1);
    #2;
    RESET = 1'b1;
    sb_q.delete();
    #1;
    check("midrst_exec1", 64'(EXEC1), 0);
    check("midrst_ir", 64'(IR), 0);
    check("midrst_retired", 64'(RETIRED), 0);
    check("midrst_halted", 64'(HALTED), 0);
    RUN = 1'b0;
    exec_idx = 0;
    instr = prog[0];
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    fetch_cnt = 0;
    repeat (4) @(negedge CLK);
    check("midrst_idle_nofetch", 64'(fetch_cnt), 0);
    push_expected(n);
    RUN = 1'b1;
    wait_halt(60, 1'b0);
    halt_hold(n);

`ifdef EXEC_SEQ_STEP_EN
    // single step out of PAUSE with a held STEP
    gen_prog(3);
    prog[0] = 16'h0040; e2_tab[0] = 1'b0;
    prog[1] = 16'h3800; e2_tab[1] = 1'b1;
    prog[2] = 16'h7E00; e2_tab[2] = 1'b0;
    do_reset();
    push_expected(3);
    RUN = 1'b1;
    cyc = 0;
    while (!EXEC1 && cyc < 20) begin @(negedge CLK); cyc++; end
    RUN = 1'b0;
    repeat (3) @(negedge CLK);
    check("step_pause_ir", 64'(IR), 16'h3800);
    check("step_pause_retired", 64'(RETIRED), 1);
    b1 = e1_cnt;
    b2 = e2_cnt;
    STEP = 1'b1;
    repeat (10) @(negedge CLK);
    check("step_one_exec1", 64'(e1_cnt - b1), 1);
    check("step_one_exec2", 64'(e2_cnt - b2), 1);
    check("step_retired", 64'(RETIRED), 2);
    check("step_ir_next", 64'(IR), 16'h7E00);
    check("step_not_halted", 64'(HALTED), 0);
    STEP = 1'b0;
    RUN = 1'b1;
    wait_halt(20, 1'b0);
    halt_hold(3);
`endif

    do_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
